cpu_state_dumper: RTL and testbench

- On-chip, synthesisable replacement for the end-of-run register printout.
- After a programmable delay or an explicit trigger, it stalls the CPU and walks a masked set of register-file entries plus the PC.
- Each value is streamed out as a tagged word over a valid/ready interface, towards a UART or trace sink.
- Sits beside the CPU and uses a dedicated read port of the register file.

---
 rtl/cpu_state_dumper_pkg.sv | 31 +++
 rtl/cpu_state_dumper_mask_next_index.sv | 26 ++
 rtl/cpu_state_dumper.sv | 199 +++++++++++++++++++
 tb/tb_cpu_state_dumper.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_state_dumper_pkg.sv
// Shared types and helpers for the CPU state dumper: FSM states, PC tag flag, width functions.
package cpu_state_dumper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HALT,
      ST_SCAN,
      ST_CAPTURE,
      ST_SEND,
      ST_PCWORD,
      ST_DONE
   } state_t;

   // The tag MSB distinguishes the PC word from register words.
   localparam logic PC_TAG_FLAG = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int addrWidth(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/cpu_state_dumper_mask_next_index.sv
// Combinational priority finder: lowest set mask bit strictly above the current index.
module mask_next_index
   import cpu_state_dumper_pkg::*;
#(
   parameter int NUM_REGS = 32,
   localparam int AW = addrWidth(NUM_REGS)
) (
   input  logic [NUM_REGS-1:0] i_mask,
   input  logic [AW-1:0]       i_cur,
   output logic [AW-1:0]       o_next,
   output logic                o_noneLeft
);

   // Scanning downwards lets the lowest qualifying bit win.
   always_comb begin
      o_next     = '0;
      o_noneLeft = 1'b1;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (i_mask[i] && (i > int'(i_cur))) begin
            o_next     = AW'(i);
            o_noneLeft = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_state_dumper.sv
// Stalls the CPU after a delay or start pulse and streams masked registers plus the PC as tagged words.
// i_reset is asynchronous and active-low.
module cpu_state_dumper
   import cpu_state_dumper_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          NUM_REGS    = 32,
   parameter logic [31:0] DUMP_MASK   = 32'h0000_04FE,
   parameter int          WAIT_CYCLES = 20,
   parameter int          PERIODIC    = 0,
   parameter int          PERIOD      = 256,
   localparam int AW = addrWidth(NUM_REGS),
   localparam int TW = AW + 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   output logic            o_halt_req,
   input  logic            i_halted,
   output logic [AW-1:0]   o_rf_raddr,
   input  logic [XLEN-1:0] i_rf_rdata,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [TW-1:0]   o_out_tag,
   output logic [XLEN-1:0] o_out_data,
   output logic            o_busy,
   output logic [7:0]      o_dump_count
);

   localparam int CNT_MAX = (WAIT_CYCLES > PERIOD) ? WAIT_CYCLES : PERIOD;
   localparam int CNT_W   = addrWidth(CNT_MAX + 1);
   localparam logic [NUM_REGS-1:0] EFF_MASK = NUM_REGS'(DUMP_MASK);
   localparam logic [TW-1:0]       PC_TAG   = {PC_TAG_FLAG, {AW{1'b0}}};

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_count;
   logic              r_armed;
   logic [AW-1:0]     r_index;
   logic [TW-1:0]     r_outTag;
   logic [XLEN-1:0]   r_outData;
   logic [7:0]        r_dumpCount;
   logic [AW-1:0]     w_searchFrom;
   logic [AW-1:0]     w_nextIndex;
   logic              w_noneLeft;
   logic              w_outValid;
   logic              w_inDump;

   // From HALT the search starts below index 1 so bit 0 never qualifies.
   assign w_searchFrom = (r_state == ST_HALT) ? '0 : r_index;

   mask_next_index #(
      .NUM_REGS (NUM_REGS)
   ) u_maskNext (
      .i_mask     (EFF_MASK),
      .i_cur      (w_searchFrom),
      .o_next     (w_nextIndex),
      .o_noneLeft (w_noneLeft)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_nextState = ST_HALT;
            end else if (r_armed) begin
               w_nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_start || (r_count <= CNT_W'(1))) begin
               w_nextState = ST_HALT;
            end
         end
         ST_HALT: begin
            if (i_halted) begin
               w_nextState = w_noneLeft ? ST_PCWORD : ST_SCAN;
            end
         end
         ST_SCAN:    w_nextState = ST_CAPTURE;
         ST_CAPTURE: w_nextState = ST_SEND;
         ST_SEND: begin
            if (i_out_ready) begin
               w_nextState = w_noneLeft ? ST_PCWORD : ST_SCAN;
            end
         end
         ST_PCWORD: begin
            if (i_out_ready) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE:    w_nextState = (PERIODIC != 0) ? ST_WAIT : ST_IDLE;
         default:    w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      o_halt_req = 1'b0;
      o_busy     = 1'b0;
      w_outValid = 1'b0;
      w_inDump   = 1'b0;
      unique case (r_state)
         ST_HALT: begin
            o_halt_req = 1'b1;
            o_busy     = 1'b1;
         end
         ST_SCAN, ST_CAPTURE: begin
            o_halt_req = 1'b1;
            o_busy     = 1'b1;
            w_inDump   = 1'b1;
         end
         ST_SEND, ST_PCWORD: begin
            o_halt_req = 1'b1;
            o_busy     = 1'b1;
            w_outValid = 1'b1;
            w_inDump   = 1'b1;
         end
         default: begin
            o_halt_req = 1'b0;
         end
      endcase
   end

   // The PC word is loaded on the edge that enters PCWORD, so it is valid for the whole state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count     <= CNT_W'(WAIT_CYCLES);
         r_armed     <= (WAIT_CYCLES > 0);
         r_index     <= '0;
         r_outTag    <= '0;
         r_outData   <= '0;
         r_dumpCount <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_armed <= 1'b0;
            end
            ST_WAIT: begin
               if (r_count != '0) begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            ST_HALT: begin
               if (i_halted) begin
                  if (w_noneLeft) begin
                     r_outData <= i_pc;
                     r_outTag  <= PC_TAG;
                  end else begin
                     r_index <= w_nextIndex;
                  end
               end
            end
            ST_CAPTURE: begin
               r_outData <= i_rf_rdata;
               r_outTag  <= {1'b0, r_index};
            end
            ST_SEND: begin
               if (i_out_ready) begin
                  if (w_noneLeft) begin
                     r_outData <= i_pc;
                     r_outTag  <= PC_TAG;
                  end else begin
                     r_index <= w_nextIndex;
                  end
               end
            end
            ST_DONE: begin
               r_count <= CNT_W'(PERIOD);
               if (r_dumpCount != 8'hFF) begin
                  r_dumpCount <= r_dumpCount + 8'd1;
               end
            end
            default: begin
               r_armed <= r_armed;
            end
         endcase
      end
   end

   assign o_rf_raddr   = r_index;
   assign o_out_valid  = w_outValid;
   assign o_out_tag    = r_outTag;
   assign o_out_data   = r_outData;
   assign o_dump_count = r_dumpCount;

   // A CPU that leaves the halted state mid-dump corrupts the snapshot; the dump still runs to completion.
   assert property (@(posedge i_clk) disable iff (!i_reset) w_inDump |-> i_halted);

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Scoreboard bench for cpu_state_dumper: a default instance (A) and a periodic PC-only instance (B).
module tb_cpu_state_dumper;

   typedef struct packed {
      logic [5:0]  tag;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   int          checks = 0;
   int          failures = 0;

   logic        resetA = 1'b0, startA = 1'b0, haltedA = 1'b0, outReadyA = 1'b1;
   logic        haltReqA, outValidA, busyA;
   logic [4:0]  rfRaddrA;
   logic [31:0] rfRdataA, pcA = 32'd64;
   logic [5:0]  outTagA;
   logic [31:0] outDataA;
   logic [7:0]  dumpCountA;

   logic        resetB = 1'b0, startB = 1'b0, haltedB = 1'b0, outReadyB = 1'b1;
   logic        haltReqB, outValidB, busyB;
   logic [4:0]  rfRaddrB;
   logic [31:0] rfRdataB, pcB = 32'h0000_1234;
   logic [5:0]  outTagB;
   logic [31:0] outDataB;
   logic [7:0]  dumpCountB;

   logic [31:0] regFile [0:31];
   word_t       qA[$];
   word_t       qB[$];
   logic        readyRandom = 1'b0;
   logic        readyLevel = 1'b1;

   always #5 clk = ~clk;

   assign rfRdataA = regFile[rfRaddrA];
   assign rfRdataB = 32'hBAD0_0000;

   // The CPU model acknowledges the stall one cycle after it is requested.
   always @(posedge clk) begin
      haltedA <= haltReqA;
      haltedB <= haltReqB;
   end

   cpu_state_dumper dutA (
      .i_clk(clk), .i_reset(resetA), .i_start(startA), .o_halt_req(haltReqA), .i_halted(haltedA),
      .o_rf_raddr(rfRaddrA), .i_rf_rdata(rfRdataA), .i_pc(pcA), .o_out_valid(outValidA),
      .i_out_ready(outReadyA), .o_out_tag(outTagA), .o_out_data(outDataA), .o_busy(busyA),
      .o_dump_count(dumpCountA)
   );

   cpu_state_dumper #(
      .DUMP_MASK(32'h0), .WAIT_CYCLES(0), .PERIODIC(1), .PERIOD(10)
   ) dutB (
      .i_clk(clk), .i_reset(resetB), .i_start(startB), .o_halt_req(haltReqB), .i_halted(haltedB),
      .o_rf_raddr(rfRaddrB), .i_rf_rdata(rfRdataB), .i_pc(pcB), .o_out_valid(outValidB),
      .i_out_ready(outReadyB), .o_out_tag(outTagB), .o_out_data(outDataB), .o_busy(busyB),
      .o_dump_count(dumpCountB)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // Pulses start for one cycle on the selected instance; called just after a rising edge.
   task automatic applyStimulus(input int which);
      if (which == 0) startA = 1'b1; else startB = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      startB = 1'b0;
   endtask

   task automatic pushDumpA();
      int tags[9] = '{1, 2, 3, 4, 5, 6, 7, 10, 0};
      for (int i = 0; i < 8; i++) begin
         qA.push_back({6'(tags[i]), regFile[tags[i]]});
      end
      qA.push_back({6'h20, pcA});
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         outReadyA = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
      end
   end

   // Monitor A: pops on every handshake and checks that a stalled word is held unchanged.
   initial begin
      logic        holdValid;
      logic [5:0]  holdTag;
      logic [31:0] holdData;
      word_t       w;
      holdValid = 1'b0;
      holdTag   = '0;
      holdData  = '0;
      forever begin
         @(negedge clk);
         if (!resetA) begin
            holdValid = 1'b0;
         end else begin
            if (holdValid) begin
               checkOutput("A valid held", 32'(outValidA), 32'd1);
               checkOutput("A tag held", 32'(outTagA), 32'(holdTag));
               checkOutput("A data held", outDataA, holdData);
            end
            if (outValidA && outReadyA) begin
               holdValid = 1'b0;
               if (qA.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL A extra word: got tag %0h data %0h, required none", outTagA, outDataA);
               end else begin
                  w = qA.pop_front();
                  checkOutput("A word tag", 32'(outTagA), 32'(w.tag));
                  checkOutput("A word data", outDataA, w.data);
               end
            end else if (outValidA) begin
               holdValid = 1'b1;
               holdTag   = outTagA;
               holdData  = outDataA;
            end else begin
               holdValid = 1'b0;
            end
         end
      end
   end

   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         if (resetB && outValidB && outReadyB) begin
            if (qB.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL B extra word: got tag %0h data %0h, required none", outTagB, outDataB);
            end else begin
               w = qB.pop_front();
               checkOutput("B word tag", 32'(outTagB), 32'(w.tag));
               checkOutput("B word data", outDataB, w.data);
            end
         end
      end
   end

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      int offset;
      int incCycle[3];
      int incIdx;
      logic [7:0] prevCount;

      for (int i = 0; i < 32; i++) regFile[i] = 32'h100 + i;
      regFile[1]  = 32'd5;
      regFile[10] = 32'd99;

      repeat (3) @(posedge clk); #1;
      checkOutput("reset halt_req", 32'(haltReqA), 32'd0);
      checkOutput("reset out_valid", 32'(outValidA), 32'd0);
      checkOutput("reset busy", 32'(busyA), 32'd0);
      checkOutput("reset rf_raddr", 32'(rfRaddrA), 32'd0);
      checkOutput("reset out_tag", 32'(outTagA), 32'd0);
      checkOutput("reset out_data", outDataA, 32'd0);
      checkOutput("reset dump_count", 32'(dumpCountA), 32'd0);

      $display("[TB] automatic dump after reset release");
      pushDumpA();
      resetA = 1'b1;
      n = 0;
      while (n < 100 && !haltReqA) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("auto halt delay", 32'(n), 32'd21);
      while (n < 200 && dumpCountA != 8'd1) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("auto dump end cycle", 32'(n), 32'd49);
      checkOutput("auto dump_count", 32'(dumpCountA), 32'd1);
      checkOutput("auto halt_req released", 32'(haltReqA), 32'd0);
      checkOutput("auto busy released", 32'(busyA), 32'd0);
      checkOutput("auto queue drained", 32'(qA.size()), 32'd0);

      $display("[TB] start-triggered dump with random out_ready and a dropped second start");
      pcA = 32'd128;
      regFile[3] = 32'hCAFE_0003;
      readyRandom = 1'b1;
      pushDumpA();
      applyStimulus(0);
      n = 0;
      while (n < 50 && !outValidA) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("start first valid", 32'(outValidA), 32'd1);
      applyStimulus(0);
      n = 0;
      while (n < 1000 && dumpCountA != 8'd2) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (40) @(posedge clk); #1;
      checkOutput("start dump_count", 32'(dumpCountA), 32'd2);
      checkOutput("start busy after", 32'(busyA), 32'd0);
      checkOutput("start queue drained", 32'(qA.size()), 32'd0);

      $display("[TB] reset asserted during SEND");
      readyRandom = 1'b0;
      readyLevel  = 1'b0;
      applyStimulus(0);
      n = 0;
      while (n < 50 && !outValidA) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("abort reached send", 32'(outValidA), 32'd1);
      @(negedge clk); #2;
      resetA = 1'b0;
      #1;
      checkOutput("abort halt_req", 32'(haltReqA), 32'd0);
      checkOutput("abort out_valid", 32'(outValidA), 32'd0);
      checkOutput("abort busy", 32'(busyA), 32'd0);
      checkOutput("abort dump_count", 32'(dumpCountA), 32'd0);
      qA.delete();
      repeat (3) @(posedge clk); #1;
      readyLevel = 1'b1;
      pushDumpA();
      resetA = 1'b1;
      n = 0;
      while (n < 200 && dumpCountA != 8'd1) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("restart end cycle", 32'(n), 32'd49);
      checkOutput("restart queue drained", 32'(qA.size()), 32'd0);

      $display("[TB] periodic PC-only instance");
      resetB = 1'b1;
      repeat (50) @(posedge clk); #1;
      checkOutput("B no auto dump", 32'(dumpCountB), 32'd0);
      checkOutput("B idle busy", 32'(busyB), 32'd0);
      for (int i = 0; i < 3; i++) qB.push_back({6'h20, pcB});
      applyStimulus(1);
      offset = 1;
      incIdx = 0;
      prevCount = 8'd0;
      incCycle = '{0, 0, 0};
      while (offset < 100 && incIdx < 3) begin
         @(posedge clk); #1;
         offset++;
         if (offset == 2) startB = 1'b1;
         if (offset == 3) startB = 1'b0;
         if (dumpCountB != prevCount) begin
            incCycle[incIdx] = offset;
            incIdx++;
            prevCount = dumpCountB;
         end
      end
      checkOutput("B dump_count", 32'(dumpCountB), 32'd3);
      resetB = 1'b0;
      checkOutput("B first dump cycle", 32'(incCycle[0]), 32'd5);
      checkOutput("B second dump cycle", 32'(incCycle[1]), 32'd19);
      checkOutput("B third dump cycle", 32'(incCycle[2]), 32'd33);
      checkOutput("B queue drained", 32'(qB.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
